// File: rtl/fcfs_quantum_scheduler.sv
// First-come-first-served ownership scheduler for one shared resource.
// Each owner holds a one-hot grant for up to max(weight,1)*QUANTUM cycles, then is re-queued.
module fcfs_quantum_scheduler #(
    parameter int REQUESTORS = 4,
    parameter int QUANTUM    = 10,
    parameter int WEIGHT_W   = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [REQUESTORS-1:0]          req,
    input  logic [REQUESTORS*WEIGHT_W-1:0] weights,
    input  logic [REQUESTORS-1:0]          done,
    output logic [REQUESTORS-1:0]          grant,
    output logic [$clog2(REQUESTORS)-1:0]  grant_id,
    output logic                           busy,
    output logic                           preempt
);
    localparam int ID_W  = $clog2(REQUESTORS);
    localparam int CNT_W = WEIGHT_W + 8;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] LOAD    = 2'd1;
    localparam logic [1:0] GRANT   = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [ID_W-1:0]       q   [REQUESTORS];
    logic [ID_W-1:0]       q_n [REQUESTORS];
    logic [ID_W-1:0]       head, head_n, tail, tail_n;
    logic [ID_W:0]         count, count_n;
    logic [REQUESTORS-1:0] queued, queued_n;

    logic [ID_W-1:0]     head_id;
    logic [WEIGHT_W-1:0] head_w, own_w;
    logic                own_release, expire, pop, requeue;

    function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] p);
        return (p == ID_W'(REQUESTORS - 1)) ? '0 : p + 1'b1;
    endfunction

    // Weight 0 counts as one unit; the product always fits in CNT_W bits.
    function automatic logic [CNT_W-1:0] budget(input logic [WEIGHT_W-1:0] w);
        logic [CNT_W-1:0] units;
        units = (w == '0) ? CNT_W'(1) : CNT_W'(w);
        return units * CNT_W'(QUANTUM);
    endfunction

    assign head_id     = q[head];
    assign head_w      = weights[int'(head_id)*WEIGHT_W +: WEIGHT_W];
    assign own_w       = weights[int'(grant_id)*WEIGHT_W +: WEIGHT_W];
    assign own_release = done[grant_id] || !req[grant_id];
    assign expire      = (cnt == CNT_W'(1));
    assign pop         = (state == LOAD);
    assign requeue     = (state == GRANT) && !own_release && expire && (count != '0);
    assign busy        = |grant;

    // Pop happens only in LOAD and the re-queue only in GRANT, so they never coincide.
    // The preempted owner goes in ahead of same-cycle arrivals since it requested earlier.
    always_comb begin
        q_n      = q;
        head_n   = head;
        tail_n   = tail;
        count_n  = count;
        queued_n = queued;
        if (pop) begin
            head_n            = ptr_inc(head);
            count_n           = count_n - 1'b1;
            queued_n[head_id] = 1'b0;
        end
        if (requeue) begin
            q_n[tail_n]        = grant_id;
            tail_n             = ptr_inc(tail_n);
            count_n            = count_n + 1'b1;
            queued_n[grant_id] = 1'b1;
        end
        for (int i = 0; i < REQUESTORS; i++) begin
            if (req[i] && !queued[i] && !(state == GRANT && grant_id == ID_W'(i))) begin
                q_n[tail_n]  = ID_W'(i);
                tail_n       = ptr_inc(tail_n);
                count_n      = count_n + 1'b1;
                queued_n[i]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            queued <= '0;
        end else begin
            head   <= head_n;
            tail   <= tail_n;
            count  <= count_n;
            queued <= queued_n;
        end
    end

    always_ff @(posedge clk) begin
        q <= q_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            cnt      <= '0;
            preempt  <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (count != '0) state <= LOAD;
                end
                LOAD: begin
                    if (req[head_id]) begin
                        grant    <= REQUESTORS'(1) << head_id;
                        grant_id <= head_id;
                        cnt      <= budget(head_w);
                        state    <= GRANT;
                    end else if (count_n == '0) begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (own_release) begin
                        grant <= '0;
                        state <= RELEASE;
                    end else if (expire) begin
                        if (count != '0) begin
                            grant   <= '0;
                            preempt <= 1'b1;
                            state   <= RELEASE;
                        end else begin
                            cnt <= budget(own_w);
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RELEASE: begin
                    state <= (count_n != '0) ? LOAD : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fcfs_quantum_scheduler.sv
// Directed bench for fcfs_quantum_scheduler: vector table plus multi-cycle sequences.
module tb_fcfs_quantum_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] weights;
    logic [3:0]  done;
    logic [3:0]  grant;
    logic [1:0]  grant_id;
    logic        busy;
    logic        preempt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fcfs_quantum_scheduler #(
        .REQUESTORS(4),
        .QUANTUM   (10),
        .WEIGHT_W  (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .weights (weights),
        .done    (done),
        .grant   (grant),
        .grant_id(grant_id),
        .busy    (busy),
        .preempt (preempt)
    );

    typedef struct {
        logic       rst_v;
        logic [3:0] req_v;
        logic [3:0] done_v;
        int         cyc;
        logic [3:0] exp_g;
        logic       exp_p;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] dn,
                       input int c, input logic [3:0] g, input logic p);
        vec_t v;
        v.rst_v = r; v.req_v = rq; v.done_v = dn; v.cyc = c; v.exp_g = g; v.exp_p = p;
        vq.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic chk_out(input string name, input logic [3:0] eg, input logic ep);
        checks++;
        if (grant !== eg || busy !== (eg != 4'b0) || preempt !== ep ||
            (eg != 4'b0 && grant_id !== idx_of(eg))) begin
            errors++;
            $display("FAIL %s grant=%b busy=%b preempt=%b id=%0d expected grant=%b preempt=%b",
                     name, grant, busy, preempt, grant_id, eg, ep);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic measure(input logic [3:0] g, output int n);
        n = 0;
        while (grant === g && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic do_reset(input logic [3:0] rq, input logic [31:0] w);
        reset = 1'b0; req = 4'b0; done = 4'b0;
        step();
        weights = w;
        reset   = 1'b1;
        req     = rq;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b0; req = 4'b0; done = 4'b0; weights = 32'h01010101;

        // reset, first grant, equal-weight rotation
        add(0, 4'b1111, 4'b0000, 2, 4'b0000, 0);
        add(1, 4'b1111, 4'b0000, 1, 4'b0000, 0);
        add(1, 4'b1111, 4'b0000, 1, 4'b0000, 0);
        add(1, 4'b1111, 4'b0000, 1, 4'b0001, 0);
        add(1, 4'b1111, 4'b0000, 9, 4'b0001, 0);
        add(1, 4'b1111, 4'b0000, 1, 4'b0000, 1);
        add(1, 4'b1111, 4'b0000, 1, 4'b0000, 0);
        add(1, 4'b1111, 4'b0000, 1, 4'b0010, 0);
        // non-owner done ignored, owner done releases and re-queues behind others
        add(1, 4'b1111, 4'b0001, 1, 4'b0010, 0);
        add(1, 4'b1111, 4'b0010, 1, 4'b0000, 0);
        add(1, 4'b1111, 4'b0000, 1, 4'b0000, 0);
        add(1, 4'b1111, 4'b0000, 1, 4'b0100, 0);
        // req[3] dropped while queued, done[2] in the 4th grant cycle
        add(1, 4'b0111, 4'b0010, 1, 4'b0100, 0);
        add(1, 4'b0111, 4'b0000, 2, 4'b0100, 0);
        add(1, 4'b0111, 4'b0100, 1, 4'b0000, 0);
        add(1, 4'b0111, 4'b0000, 1, 4'b0000, 0);
        add(1, 4'b0111, 4'b0000, 1, 4'b0000, 0);
        add(1, 4'b0111, 4'b0000, 1, 4'b0001, 0);
        // FCFS: req[3] first, req[1] three cycles later
        add(0, 4'b0000, 4'b0000, 1, 4'b0000, 0);
        add(1, 4'b1000, 4'b0000, 1, 4'b0000, 0);
        add(1, 4'b1000, 4'b0000, 1, 4'b0000, 0);
        add(1, 4'b1000, 4'b0000, 1, 4'b1000, 0);
        add(1, 4'b1010, 4'b0000, 1, 4'b1000, 0);
        add(1, 4'b1010, 4'b0000, 8, 4'b1000, 0);
        add(1, 4'b1010, 4'b0000, 1, 4'b0000, 1);
        add(1, 4'b1010, 4'b0000, 1, 4'b0000, 0);
        add(1, 4'b1010, 4'b0000, 1, 4'b0010, 0);
        // simultaneous arrivals: lower index first
        add(0, 4'b0000, 4'b0000, 1, 4'b0000, 0);
        add(1, 4'b0101, 4'b0000, 2, 4'b0000, 0);
        add(1, 4'b0101, 4'b0000, 1, 4'b0001, 0);
        add(1, 4'b0100, 4'b0000, 1, 4'b0000, 0);
        add(1, 4'b0100, 4'b0000, 1, 4'b0000, 0);
        add(1, 4'b0100, 4'b0000, 1, 4'b0100, 0);

        step();
        foreach (vq[i]) begin
            reset = vq[i].rst_v;
            req   = vq[i].req_v;
            done  = vq[i].done_v;
            repeat (vq[i].cyc) step();
            chk_out($sformatf("vec%0d", i), vq[i].exp_g, vq[i].exp_p);
        end
        done = 4'b0;

        // single requester reloads with no gap and no preempt
        do_reset(4'b0100, 32'h00020000);
        repeat (3) step();
        chk_out("single_first", 4'b0100, 1'b0);
        for (int c = 0; c < 65; c++) begin
            step();
            chk_out($sformatf("single_hold%0d", c), 4'b0100, 1'b0);
        end

        // weighted preemption: weight 1 -> 10 cycles, weight 3 -> 30 cycles
        do_reset(4'b0011, 32'h00000301);
        repeat (3) step();
        chk_out("pre_first", 4'b0001, 1'b0);
        measure(4'b0001, n);
        chk_int("pre_run0", n, 10);
        chk_out("pre_pulse0", 4'b0000, 1'b1);
        measure(4'b0000, n);
        chk_int("pre_gap0", n, 2);
        chk_out("pre_own1", 4'b0010, 1'b0);
        measure(4'b0010, n);
        chk_int("pre_run1", n, 30);
        chk_out("pre_pulse1", 4'b0000, 1'b1);
        measure(4'b0000, n);
        chk_int("pre_gap1", n, 2);
        chk_out("pre_back0", 4'b0001, 1'b0);

        // weight 0 behaves as weight 1
        do_reset(4'b0011, 32'h00000100);
        repeat (3) step();
        chk_out("w0_first", 4'b0001, 1'b0);
        measure(4'b0001, n);
        chk_int("w0_run", n, 10);

        // reset mid-grant drops grant at once and empties the queue
        do_reset(4'b0110, 32'h01010101);
        repeat (3) step();
        chk_out("rmg_own", 4'b0010, 1'b0);
        step();
        #3 reset = 1'b0;
        #1 chk_out("rmg_async", 4'b0000, 1'b0);
        chk_int("rmg_id", int'(grant_id), 0);
        req = 4'b0100;
        step();
        reset = 1'b1;
        step();
        chk_out("rmg_e1", 4'b0000, 1'b0);
        step();
        chk_out("rmg_e2", 4'b0000, 1'b0);
        step();
        chk_out("rmg_e3", 4'b0100, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fcfs_quantum_scheduler.md
# fcfs_quantum_scheduler

Time-sliced scheduler for a single shared resource: requesters are granted ownership in first-come-first-served order, and each ownership lasts up to a weighted quantum. It tracks arrival order in an internal ID queue and holds a one-hot grant until the owner releases it, drops its request, or uses up its budget. On expiry the owner is preempted and re-queued at the tail. It drives the same req/grant/weights signalling used by the arbiter interface and adds an explicit release (done) handshake and a preemption indication.

## Interface
- REQUESTORS, 4, number of requesters (2..16)
- QUANTUM, 10, cycles per unit weight (1..255)
- WEIGHT_W, 8, width of each weight field

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req  in  REQUESTORS  level request per requester
- weights  in  REQUESTORS*WEIGHT_W  weight of requester i in bits [i*WEIGHT_W +: WEIGHT_W]
- done  in  REQUESTORS  owner release pulse; only done[grant_id] is honoured
- grant  out  REQUESTORS  one-hot ownership, registered
- grant_id  out  $clog2(REQUESTORS)  index of current owner; valid when busy=1
- busy  out  1  grant != 0
- preempt  out  1  one-cycle pulse after a budget expiry that re-queued the owner

## Operation
- **Order queue**
  - Circular FIFO of requester IDs, depth REQUESTORS, plus a queued[] bitmap.
  - Each cycle, every i with req[i]=1, queued[i]=0 and not current owner is pushed.
  - Simultaneous pushes are entered in ascending index order.
  - Each ID is in the queue at most once, so the queue cannot overflow.
  - queued[i] clears on pop.
- **FSM states:** IDLE, LOAD, GRANT, RELEASE.
- **IDLE**
  - grant=0.
  - Queue non-empty → LOAD.
- **LOAD**
  - Pop the head ID h.
  - If req[h]=0: the entry is discarded (stale). Stay in LOAD if the queue is still non-empty, else go to IDLE.
  - Otherwise: latch budget = max(weights[h],1) * QUANTUM, register grant=1<<h and grant_id=h, go to GRANT.
- **GRANT**
  - The counter decrements once per cycle.
  - Exit conditions are evaluated each cycle, in priority order:
    1. done[h]=1 or req[h]=0 → RELEASE, no re-queue, preempt=0.
    2. Counter==1 and queue non-empty → RELEASE. h is pushed to the tail at that edge and preempt=1 in the RELEASE cycle.
    3. Counter==1 and queue empty → counter reloads with the freshly sampled weight. Grant is held with no gap and no preempt.
- **RELEASE**
  - grant=0 for one turnaround cycle.
  - Then LOAD if the queue is non-empty, else IDLE.
- **Arithmetic**
  - Counter width is WEIGHT_W+8.
  - The product is unsigned and cannot overflow.
  - Weight 0 is treated as 1.
  - Weights are sampled only at LOAD or reload; mid-grant changes are ignored.
- **Ignored inputs:** done bits of non-owners.
- **Re-request after done:** an owner that released via done but keeps req high is re-pushed in the RELEASE cycle (it joins behind existing entries).

## Timing
- **Reset (asynchronous, reset=0):**
  - grant=0, grant_id=0, busy=0, preempt=0.
  - Queue empty, queued[] cleared, counter=0, state IDLE.
  - A reset mid-grant drops grant immediately, without waiting for a clock edge.
- **First grant:** req[i] rises and is pushed at edge k (empty queue, IDLE). The FSM enters LOAD at edge k+1, and grant is high after edge k+2.
- **Budget:** an uncontested owner holds grant for exactly budget cycles.
- **Handover gap:** exactly 2 cycles with grant=0 (RELEASE, then LOAD) between owners, or 3 or more if stale entries are skipped (one extra cycle per stale entry).
- **done response:** done[h] sampled high at edge m → grant=0 after edge m.
- **preempt:** high for exactly one cycle, coincident with RELEASE.
- **Grant invariants:**
  - grant is always one-hot or zero.
  - grant never changes owner without a zero cycle in between, except when reset is asserted.

## Test plan
- **Reset:** reset=0 with req=4'b1111 → grant=0, busy=0, preempt=0. Release reset at t → first grant 4'b0001 after the third rising edge.
- **Single requester:** req[2] only, weights[2]=2, QUANTUM=10, no done → grant=4'b0100 continuously, counter reloads every 20 cycles, preempt never asserts.
- **FCFS order:**
  - req[3] rises at cycle 0 and req[1] at cycle 3 → grant 4'b1000, then 4'b0010.
  - req[0] and req[2] rise in the same cycle → 0 is served before 2.
- **Preemption:** req[0] (weight 1) and req[1] (weight 3) held high → grant[0] for 10 cycles, preempt pulse, 2-cycle gap, grant[1] for 30 cycles, preempt, then back to grant[0].
- **Release and non-owner done:** done[2] in the 4th grant cycle of owner 2 → grant drops next edge, preempt=0. A done[1] pulse while 2 owns the resource → no effect.
- **Stale entry and reset mid-grant:** req[3] dropped while queued → skipped at LOAD with one extra gap cycle. Assert reset mid-grant → grant=0 immediately and the queue is empty after reset.
